// File: rtl/local_mem_bank_arbiter_if.sv
// Request/response bundle between N OBI masters, the bank arbiter and one local-memory bank.
// The arbiter takes the slave view; the masters plus the bank model take the master view.
interface local_mem_bank_arbiter_if #(
   parameter int NUM_MASTER      = 4,
   parameter int MAX_OUTSTANDING = 2
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [NUM_MASTER-1:0]        m_req_i;
   logic [NUM_MASTER-1:0]        m_we_i;
   logic [NUM_MASTER-1:0][3:0]   m_be_i;
   logic [NUM_MASTER-1:0][31:0]  m_addr_i;
   logic [NUM_MASTER-1:0][31:0]  m_wdata_i;
   logic [NUM_MASTER-1:0]        m_gnt_o;
   logic [NUM_MASTER-1:0]        m_rvalid_o;
   logic [31:0]                  m_rdata_o;

   logic                         s_req_o;
   logic                         s_we_o;
   logic [3:0]                   s_be_o;
   logic [31:0]                  s_addr_o;
   logic [31:0]                  s_wdata_o;
   logic                         s_gnt_i;
   logic                         s_rvalid_i;
   logic [31:0]                  s_rdata_i;

   logic [CW-1:0]                outstanding_o;
   logic                         protocol_err_o;

   modport slave (
      input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
      output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
             outstanding_o, protocol_err_o
   );

   modport master (
      output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
      input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
             outstanding_o, protocol_err_o
   );
endinterface

// File: rtl/local_mem_bank_arbiter.sv
// Round-robin arbiter sharing one OBI local-memory bank among NUM_MASTER requesters,
// with grant locking under bank backpressure and an in-order ID FIFO for response routing.
module local_mem_bank_arbiter #(
   parameter int NUM_MASTER      = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input logic clk_i,
   input logic rst_i,
   local_mem_bank_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_MASTER);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t   state, state_nxt;
   logic [IW-1:0] lock_idx, lock_idx_nxt;
   logic [IW-1:0] rr_ptr, rr_pick, winner, head;
   logic [CW-1:0] cnt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] id_mem [MAX_OUTSTANDING];
   logic          eligible, lock_hold, lock_drop;
   logic          s_req, hs, pop, stray_rvalid;
   logic [NUM_MASTER-1:0] gnt_vec, rvalid_vec;

   assign eligible     = cnt < CW'(MAX_OUTSTANDING);
   assign lock_hold    = (state == LOCKED) &&  bus.m_req_i[lock_idx];
   assign lock_drop    = (state == LOCKED) && !bus.m_req_i[lock_idx];
   assign s_req        = !rst_i && eligible && (|bus.m_req_i);
   assign hs           = s_req && bus.s_gnt_i;
   assign pop          = !rst_i && bus.s_rvalid_i && (cnt != '0);
   assign stray_rvalid = bus.s_rvalid_i && (cnt == '0);
   assign head         = id_mem[rd_ptr];

   // Descending scan so the lowest cyclic offset from rr_ptr is the last (winning) write.
   always_comb begin
      logic [IW-1:0] cand;
      rr_pick = '0;
      cand    = '0;
      for (int k = NUM_MASTER - 1; k >= 0; k--) begin
         cand = IW'((int'(rr_ptr) + k) % NUM_MASTER);
         if (bus.m_req_i[cand]) rr_pick = cand;
      end
   end

   // A dropped lock falls back to normal arbitration in the same cycle.
   assign winner = lock_hold ? lock_idx : rr_pick;

   always_comb begin
      state_nxt    = state;
      lock_idx_nxt = lock_idx;
      case (state)
         UNLOCKED: if (s_req && !bus.s_gnt_i) begin
            state_nxt    = LOCKED;
            lock_idx_nxt = winner;
         end
         LOCKED: begin
            if (s_req && !bus.s_gnt_i) begin
               state_nxt    = LOCKED;
               lock_idx_nxt = winner;
            end else begin
               state_nxt = UNLOCKED;
            end
         end
         default: state_nxt = UNLOCKED;
      endcase
   end

   always_comb begin
      gnt_vec    = '0;
      rvalid_vec = '0;
      gnt_vec[winner]  = hs;
      rvalid_vec[head] = pop;
   end

   assign bus.m_gnt_o        = gnt_vec;
   assign bus.m_rvalid_o     = rvalid_vec;
   assign bus.m_rdata_o      = bus.s_rdata_i;
   assign bus.s_req_o        = s_req;
   assign bus.s_we_o         = bus.m_we_i[winner];
   assign bus.s_be_o         = bus.m_be_i[winner];
   assign bus.s_addr_o       = bus.m_addr_i[winner];
   assign bus.s_wdata_o      = bus.m_wdata_i[winner];
   assign bus.outstanding_o  = cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state              <= UNLOCKED;
         lock_idx           <= '0;
         rr_ptr             <= '0;
         cnt                <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         bus.protocol_err_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_idx <= lock_idx_nxt;
         if (hs) begin
            rr_ptr <= (winner == IW'(NUM_MASTER - 1)) ? '0 : winner + 1'b1;
            wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
         case ({hs, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (stray_rvalid || lock_drop) bus.protocol_err_o <= 1'b1;
      end
   end

   // ID storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge clk_i) begin
      if (hs) id_mem[wr_ptr] <= winner;
   end
endmodule

// File: tb/tb_local_mem_bank_arbiter.sv
// Directed bench for local_mem_bank_arbiter: rotation, locking, backpressure,
// stray responses and reset behaviour, with hand-computed expectations.
module tb_local_mem_bank_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec  = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   local_mem_bank_arbiter_if #(.NUM_MASTER(4), .MAX_OUTSTANDING(2)) bus ();

   local_mem_bank_arbiter #(.NUM_MASTER(4), .MAX_OUTSTANDING(2)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   function automatic logic [31:0] addr_of(input int i);
      return 32'h0000_1000 + 32'(i) * 32'h100;
   endfunction

   function automatic logic [31:0] wdata_of(input int i);
      return 32'hD000_0000 + 32'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] req, input logic gnt, input logic rv);
      bus.m_req_i    = req;
      bus.s_gnt_i    = gnt;
      bus.s_rvalid_i = rv;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'b1111, 1'b1, 1'b1);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0000) begin errs++; $display("FAIL rst_gnt: got %b want 0000", bus.m_gnt_o); end
      vec++; if (bus.m_rvalid_o !== 4'b0000) begin errs++; $display("FAIL rst_rvalid: got %b want 0000", bus.m_rvalid_o); end
      vec++; if (bus.outstanding_o !== 2'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", bus.outstanding_o); end
      tick();
      vec++; if (bus.protocol_err_o !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", bus.protocol_err_o); end
      bus.s_rdata_i = 32'hCAFE_0001;
      #1;
      vec++; if (bus.m_rdata_o !== 32'hCAFE_0001) begin errs++; $display("FAIL rdata_pass: got %h want cafe0001", bus.m_rdata_o); end
      drive(4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
   endtask

   // All four request, bank always grants and answers one cycle later.
   task automatic test_rotate();
      logic [3:0] eg, er;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive((k < 5) ? 4'b1111 : 4'b0000, 1'b1, k > 0);
         #1;
         eg = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
         er = (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
         vec++; if (bus.m_gnt_o !== eg) begin errs++; $display("FAIL rot_gnt%0d: got %b want %b", k, bus.m_gnt_o, eg); end
         vec++; if (bus.m_rvalid_o !== er) begin errs++; $display("FAIL rot_rvalid%0d: got %b want %b", k, bus.m_rvalid_o, er); end
         vec++; if (bus.outstanding_o !== ((k == 0) ? 2'd0 : 2'd1)) begin errs++; $display("FAIL rot_cnt%0d: got %0d want %0d", k, bus.outstanding_o, (k == 0) ? 0 : 1); end
         if (k < 5) begin
            vec++; if (bus.s_addr_o !== addr_of(k % 4)) begin errs++; $display("FAIL rot_addr%0d: got %h want %h", k, bus.s_addr_o, addr_of(k % 4)); end
         end
         tick();
      end
      drive(4'b0000, 1'b0, 1'b0);
      #1;
      vec++; if (bus.outstanding_o !== 2'd0) begin errs++; $display("FAIL rot_drain: got %0d want 0", bus.outstanding_o); end
   endtask

   // Masters 0/2 stalled three cycles, master 1 joins; then fill to the limit and drain.
   task automatic test_lock();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive((k == 2) ? 4'b0111 : 4'b0101, 1'b0, 1'b0);
         #1;
         vec++; if (bus.s_req_o !== 1'b1) begin errs++; $display("FAIL lk_sreq%0d: got %b want 1", k, bus.s_req_o); end
         vec++; if (bus.s_addr_o !== addr_of(0)) begin errs++; $display("FAIL lk_addr%0d: got %h want %h", k, bus.s_addr_o, addr_of(0)); end
         vec++; if (bus.m_gnt_o !== 4'b0000) begin errs++; $display("FAIL lk_gnt%0d: got %b want 0000", k, bus.m_gnt_o); end
         tick();
      end
      drive(4'b0111, 1'b1, 1'b0);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0001) begin errs++; $display("FAIL lk_win0: got %b want 0001", bus.m_gnt_o); end
      vec++; if (bus.s_wdata_o !== wdata_of(0)) begin errs++; $display("FAIL lk_wdata: got %h want %h", bus.s_wdata_o, wdata_of(0)); end
      tick();
      drive(4'b0110, 1'b1, 1'b0);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0010) begin errs++; $display("FAIL lk_win1: got %b want 0010", bus.m_gnt_o); end
      vec++; if (bus.outstanding_o !== 2'd1) begin errs++; $display("FAIL lk_cnt1: got %0d want 1", bus.outstanding_o); end
      tick();
      drive(4'b0100, 1'b1, 1'b0);
      #1;
      vec++; if (bus.s_req_o !== 1'b0) begin errs++; $display("FAIL full_sreq: got %b want 0", bus.s_req_o); end
      vec++; if (bus.outstanding_o !== 2'd2) begin errs++; $display("FAIL full_cnt: got %0d want 2", bus.outstanding_o); end
      tick();
      drive(4'b0100, 1'b1, 1'b1);
      #1;
      vec++; if (bus.s_req_o !== 1'b0 || bus.m_gnt_o !== 4'b0000) begin errs++; $display("FAIL full_rv_gnt: got sreq=%b gnt=%b want 0/0000", bus.s_req_o, bus.m_gnt_o); end
      vec++; if (bus.m_rvalid_o !== 4'b0001) begin errs++; $display("FAIL full_rv_id: got %b want 0001", bus.m_rvalid_o); end
      tick();
      #1;
      vec++; if (bus.m_rvalid_o !== 4'b0010) begin errs++; $display("FAIL pp_rv_id: got %b want 0010", bus.m_rvalid_o); end
      vec++; if (bus.m_gnt_o !== 4'b0100) begin errs++; $display("FAIL pp_gnt: got %b want 0100", bus.m_gnt_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b1);
      #1;
      vec++; if (bus.outstanding_o !== 2'd1) begin errs++; $display("FAIL pp_cnt: got %0d want 1", bus.outstanding_o); end
      vec++; if (bus.m_rvalid_o !== 4'b0100) begin errs++; $display("FAIL pp_rv_id2: got %b want 0100", bus.m_rvalid_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b0);
      #1;
      vec++; if (bus.outstanding_o !== 2'd0 || bus.protocol_err_o !== 1'b0) begin errs++; $display("FAIL lk_end: got cnt=%0d err=%b want 0/0", bus.outstanding_o, bus.protocol_err_o); end
   endtask

   // Locked on master 2 while rr_ptr=0; master 0 arriving must not preempt.
   task automatic test_no_preempt();
      do_reset();
      drive(4'b0100, 1'b0, 1'b0);
      tick();
      drive(4'b0101, 1'b0, 1'b0);
      #1;
      vec++; if (bus.s_addr_o !== addr_of(2)) begin errs++; $display("FAIL np_addr: got %h want %h", bus.s_addr_o, addr_of(2)); end
      tick();
      drive(4'b0101, 1'b1, 1'b0);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0100) begin errs++; $display("FAIL np_gnt2: got %b want 0100", bus.m_gnt_o); end
      tick();
      drive(4'b0001, 1'b1, 1'b0);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0001) begin errs++; $display("FAIL np_gnt0: got %b want 0001", bus.m_gnt_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b1);
      #1;
      vec++; if (bus.m_rvalid_o !== 4'b0100) begin errs++; $display("FAIL np_rv2: got %b want 0100", bus.m_rvalid_o); end
      tick();
      #1;
      vec++; if (bus.m_rvalid_o !== 4'b0001) begin errs++; $display("FAIL np_rv0: got %b want 0001", bus.m_rvalid_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b0);
   endtask

   // Master 1 withdraws while locked: error flag, lock released to master 2.
   task automatic test_lock_drop();
      do_reset();
      drive(4'b0010, 1'b0, 1'b0);
      tick();
      drive(4'b0100, 1'b0, 1'b0);
      #1;
      vec++; if (bus.s_addr_o !== addr_of(2)) begin errs++; $display("FAIL ld_addr: got %h want %h", bus.s_addr_o, addr_of(2)); end
      tick();
      vec++; if (bus.protocol_err_o !== 1'b1) begin errs++; $display("FAIL ld_err: got %b want 1", bus.protocol_err_o); end
      drive(4'b0000, 1'b0, 1'b0);
   endtask

   // Stray response right at reset release; flag is sticky until next reset.
   task automatic test_stray_rvalid();
      rst = 1'b1;
      drive(4'b0000, 1'b0, 1'b1);
      tick();
      vec++; if (bus.protocol_err_o !== 1'b0) begin errs++; $display("FAIL st_inrst: got %b want 0", bus.protocol_err_o); end
      rst = 1'b0;
      #1;
      vec++; if (bus.m_rvalid_o !== 4'b0000) begin errs++; $display("FAIL st_rv: got %b want 0000", bus.m_rvalid_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b0);
      vec++; if (bus.protocol_err_o !== 1'b1 || bus.outstanding_o !== 2'd0) begin errs++; $display("FAIL st_err: got err=%b cnt=%0d want 1/0", bus.protocol_err_o, bus.outstanding_o); end
      tick();
      tick();
      vec++; if (bus.protocol_err_o !== 1'b1) begin errs++; $display("FAIL st_sticky: got %b want 1", bus.protocol_err_o); end
      rst = 1'b1;
      #1;
      vec++; if (bus.protocol_err_o !== 1'b0) begin errs++; $display("FAIL st_clr: got %b want 0", bus.protocol_err_o); end
      rst = 1'b0;
      #1;
   endtask

   // Reset mid-flight with two outstanding: IDs dropped, rr_ptr back to 0.
   task automatic test_reset_mid();
      do_reset();
      drive(4'b1111, 1'b1, 1'b0);
      tick();
      tick();
      vec++; if (bus.outstanding_o !== 2'd2) begin errs++; $display("FAIL rm_pre: got %0d want 2", bus.outstanding_o); end
      rst = 1'b1;
      #1;
      vec++; if (bus.outstanding_o !== 2'd0) begin errs++; $display("FAIL rm_cnt: got %0d want 0", bus.outstanding_o); end
      rst = 1'b0;
      drive(4'b0000, 1'b0, 1'b1);
      #1;
      vec++; if (bus.m_rvalid_o !== 4'b0000) begin errs++; $display("FAIL rm_rv: got %b want 0000", bus.m_rvalid_o); end
      tick();
      vec++; if (bus.protocol_err_o !== 1'b1) begin errs++; $display("FAIL rm_late: got %b want 1", bus.protocol_err_o); end
      drive(4'b1111, 1'b1, 1'b0);
      #1;
      vec++; if (bus.m_gnt_o !== 4'b0001) begin errs++; $display("FAIL rm_gnt: got %b want 0001", bus.m_gnt_o); end
      tick();
      drive(4'b0000, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         bus.m_addr_i[i]  = addr_of(i);
         bus.m_wdata_i[i] = wdata_of(i);
         bus.m_be_i[i]    = 4'(1 << i);
      end
      bus.m_we_i    = 4'b0101;
      bus.s_rdata_i = 32'h0;
      drive(4'b0000, 1'b0, 1'b0);
      #2;
      test_reset();
      test_rotate();
      test_lock();
      test_no_preempt();
      test_lock_drop();
      test_stray_rvalid();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/local_mem_bank_arbiter.md
LOCAL_MEM_BANK_ARBITER -- requirements
Module: local_mem_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTER, default 4: number of OBI requesters sharing one local-memory bank (>=2).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 2: maximum accepted-but-unanswered bank transactions (>=1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 is the clock; rst_i input 1 is the reset.
REQ-004 m_req_i  input  NUM_MASTER  per-master request.
REQ-005 m_we_i  input  NUM_MASTER  per-master write enable.
REQ-006 m_be_i  input  NUM_MASTERx4  per-master byte enables.
REQ-007 m_addr_i  input  NUM_MASTERx32  per-master bank-local address.
REQ-008 m_wdata_i  input  NUM_MASTERx32  per-master write data.
REQ-009 m_gnt_o  output  NUM_MASTER  per-master grant.
REQ-010 m_rvalid_o  output  NUM_MASTER  per-master response valid.
REQ-011 m_rdata_o  output  32  response data, broadcast to all masters.
REQ-012 s_req_o / s_we_o / s_be_o / s_addr_o / s_wdata_o  output  1/1/4/32/32  bank-side OBI request.
REQ-013 s_gnt_i  input  1  bank grant.
REQ-014 s_rvalid_i / s_rdata_i  input  1/32  bank response, in order.
REQ-015 outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
REQ-016 protocol_err_o  output  1  sticky error flag.

Function
REQ-017 Eligibility: a new request SHALL be presented only when outstanding count < MAX_OUTSTANDING; at count == MAX_OUTSTANDING, s_req_o = 0 and all m_gnt_o = 0, even if s_rvalid_i is high that cycle.
REQ-018 Arbitration: when eligible and unlocked, the winner SHALL be the first master with m_req_i set, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_MASTER).
REQ-019 s_req_o SHALL be 1 iff eligible and (locked or any m_req_i set); s_we/be/addr/wdata SHALL mux the selected master's fields combinationally.
REQ-020 Lock: if s_req_o = 1 and s_gnt_i = 0 at a clock edge, the selected master SHALL be registered and held as winner until the handshake; new higher-priority requests SHALL NOT preempt it.
REQ-021 Handshake: m_gnt_o[winner] = s_req_o & s_gnt_i, combinational; all other m_gnt_o bits = 0.
REQ-022 On handshake: push winner index into an ID FIFO of depth MAX_OUTSTANDING; set rr_ptr = (winner+1) mod NUM_MASTER; clear the lock.
REQ-023 Response: when s_rvalid_i = 1 and the FIFO is non-empty, m_rvalid_o[head] = 1 in the same cycle (zero latency); pop the head at the edge.
REQ-024 m_rdata_o SHALL equal s_rdata_i at all times.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged; the FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-026 s_rvalid_i = 1 with an empty FIFO SHALL set protocol_err_o = 1 (sticky), assert no m_rvalid_o, and leave the count at 0.
REQ-027 Every transaction, including writes, SHALL consume a FIFO entry and expects exactly one s_rvalid_i.
REQ-028 Masters SHALL hold m_req_i and their request fields stable until granted.
REQ-029 A master dropping m_req_i while locked is a protocol violation: protocol_err_o SHALL be set and the lock released.

Reset
REQ-030 While rst_i = 1 (asynchronous): rr_ptr = 0, lock cleared, FIFO empty, outstanding_o = 0, protocol_err_o = 0.
REQ-031 While rst_i = 1, m_gnt_o = 0 and m_rvalid_o = 0 regardless of inputs.
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding IDs; a late s_rvalid_i after reset SHALL raise protocol_err_o.

Verification
REQ-033 All m_req_i = 4'b1111, s_gnt_i = 1, s_rvalid_i one cycle after each grant -> grants rotate 0,1,2,3,0; each m_rvalid_o follows its grant by 1 cycle.
REQ-034 Masters 0 and 2 request, s_gnt_i = 0 for 3 cycles, master 1 raises m_req_i in cycle 2 -> master 0 stays selected, is granted when s_gnt_i = 1, then master 1 wins next.
REQ-035 MAX_OUTSTANDING = 2, s_gnt_i = 1, no s_rvalid_i -> two grants, then s_req_o = 0 with outstanding_o = 2; one s_rvalid_i -> rvalid goes to the first granted master, next grant occurs the following cycle.
REQ-036 Grant and s_rvalid_i in the same cycle at outstanding_o = 1 -> outstanding_o stays 1; IDs are returned in grant order.
REQ-037 s_rvalid_i pulse at reset release with an empty FIFO -> protocol_err_o = 1 and stays 1 until the next rst_i.
REQ-038 rst_i pulsed with 2 outstanding -> outstanding_o = 0 and rr_ptr = 0; the next 4'b1111 request is granted to master 0.
